// File: rtl/pointwise_accum.sv
// pointwise_accum: reduction stage behind the pointwise datapath.
// Sums each group of VEC_LEN signed 16-bit samples, scales the sum by a
// rounded arithmetic right shift, saturates to 16 bits and hands one word
// per group downstream over a valid/ready handshake.
module pointwise_accum #(
    parameter int VEC_LEN = 16,
    parameter int ACC_W   = 24,
    parameter int SHIFT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        clear,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_sat
);

    localparam int CNT_W = $clog2(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);
    localparam logic signed [ACC_W:0] MAX_OUT = (ACC_W+1)'(32767);
    localparam logic signed [ACC_W:0] MIN_OUT = (ACC_W+1)'(-32768);

    typedef enum logic {
        ACCUM,
        DRAIN
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic                      outValid_q, outValid_d;
    logic        [15:0]        outData_q, outData_d;
    logic                      outSat_q, outSat_d;

    logic signed [ACC_W-1:0]   sampleExt;
    logic signed [ACC_W:0]     sumWide;
    logic signed [ACC_W:0]     roundedWide;
    logic        [15:0]        clipData;
    logic                      clipSat;

    // The sum is formed one bit wider than the accumulator so the rounding
    // increment can never wrap, even when ACC_W sits at its minimum legal width.
    assign sampleExt = {{(ACC_W-16){in_data[15]}}, in_data};
    assign sumWide   = {acc_q[ACC_W-1], acc_q} + {sampleExt[ACC_W-1], sampleExt};

    // Round half up toward +inf, then shift; with no shift the sum passes through.
    generate
        if (SHIFT > 0) begin : gen_round
            localparam logic signed [ACC_W:0] ROUND_INC = (ACC_W+1)'(1 << (SHIFT - 1));
            assign roundedWide = $signed(sumWide + ROUND_INC) >>> SHIFT;
        end else begin : gen_noround
            assign roundedWide = sumWide;
        end
    endgenerate

    // Saturate the scaled sum into the 16-bit signed output range.
    always_comb begin
        clipData = roundedWide[15:0];
        clipSat  = 1'b0;
        if (roundedWide > MAX_OUT) begin
            clipData = 16'h7FFF;
            clipSat  = 1'b1;
        end else if (roundedWide < MIN_OUT) begin
            clipData = 16'h8000;
            clipSat  = 1'b1;
        end
    end

    // Next-state logic: accumulate in ACCUM (clear wins over a sample), capture the result on the last sample, and hold it in DRAIN until taken.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSat_d   = outSat_q;
        case (state_q)
            ACCUM: begin
                if (clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (in_valid) begin
                    if (cnt_q == LAST_CNT) begin
                        outData_d  = clipData;
                        outSat_d   = clipSat;
                        outValid_d = 1'b1;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = DRAIN;
                    end else begin
                        acc_d = sumWide[ACC_W-1:0];
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    state_d    = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State and output registers; reset throws away any partial or pending group.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSat_q   <= outSat_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_sat   = outSat_q;

endmodule

// File: tb/tb_pointwise_accum.sv
// tb_pointwise_accum: drives a default instance (SHIFT=4) and a SHIFT=0
// instance, and compares both against a group-sum reference model.
module tb_pointwise_accum;

    localparam int VEC_LEN = 16;

    logic              clk = 1'b0;
    logic              rstN;
    logic [1:0]        inValid;
    logic [1:0]        inReady;
    logic [1:0]        clear;
    logic [1:0]        outValid;
    logic [1:0]        outReady;
    logic [1:0]        outSat;
    logic [1:0][15:0]  inData;
    logic [1:0][15:0]  outData;

    int checks   = 0;
    int failures = 0;

    // Reference model state, one slot per instance.
    int          shiftOf[2] = '{4, 0};
    bit          pending[2];
    logic [15:0] expData[2];
    logic        expSat[2];
    longint      grpSum[2];
    int          grpCnt[2];
    logic [15:0] delivered[2];
    logic        deliveredSat[2];
    bit          hs[2];
    logic [16:0] refRes;

    always #5 clk = ~clk;

    pointwise_accum dutDefault (
        .clk       (clk),
        .rst       (rstN),
        .in_valid  (inValid[0]),
        .in_ready  (inReady[0]),
        .in_data   (inData[0]),
        .clear     (clear[0]),
        .out_valid (outValid[0]),
        .out_ready (outReady[0]),
        .out_data  (outData[0]),
        .out_sat   (outSat[0])
    );

    pointwise_accum #(.SHIFT(0)) dutShift0 (
        .clk       (clk),
        .rst       (rstN),
        .in_valid  (inValid[1]),
        .in_ready  (inReady[1]),
        .in_data   (inData[1]),
        .clear     (clear[1]),
        .out_valid (outValid[1]),
        .out_ready (outReady[1]),
        .out_data  (outData[1]),
        .out_sat   (outSat[1])
    );

    // Reduce a finished group sum: rounded floor division by 2^sh, then clip to 16 bits.
    function automatic logic [16:0] refResult(input longint sum, input int sh);
        longint r;
        longint d;
        logic [16:0] res;
        if (sh > 0) begin
            d = longint'(1) << sh;
            r = sum + d / 2;
            if (r < 0 && (r % d) != 0) r = r / d - 1;
            else                       r = r / d;
        end else begin
            r = sum;
        end
        if (r > 32767)       res = {1'b1, 16'h7FFF};
        else if (r < -32768) res = {1'b1, 16'h8000};
        else                 res = {1'b0, r[15:0]};
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int s = 0; s < 2; s++) begin
            pending[s] = 1'b0;
            grpSum[s]  = 0;
            grpCnt[s]  = 0;
        end
    endtask

    // One clock period: check both instances mid-cycle, advance the model, then move to the next falling edge.
    task automatic stepCycle();
        #1;
        for (int s = 0; s < 2; s++) begin
            checkOutput($sformatf("inReady%0d", s), 32'(inReady[s]), 32'(!pending[s]));
            checkOutput($sformatf("outValid%0d", s), 32'(outValid[s]), 32'(pending[s]));
            if (pending[s]) begin
                checkOutput($sformatf("outData%0d", s), 32'(outData[s]), 32'(expData[s]));
                checkOutput($sformatf("outSat%0d", s), 32'(outSat[s]), 32'(expSat[s]));
            end
            hs[s] = 1'b0;
            if (pending[s]) begin
                if (outReady[s]) begin
                    delivered[s]    = outData[s];
                    deliveredSat[s] = outSat[s];
                    pending[s]      = 1'b0;
                end
            end else begin
                hs[s] = inValid[s];
                if (clear[s]) begin
                    grpSum[s] = 0;
                    grpCnt[s] = 0;
                end else if (inValid[s]) begin
                    grpSum[s] += longint'($signed(inData[s]));
                    grpCnt[s]++;
                    if (grpCnt[s] == VEC_LEN) begin
                        refRes     = refResult(grpSum[s], shiftOf[s]);
                        expSat[s]  = refRes[16];
                        expData[s] = refRes[15:0];
                        pending[s] = 1'b1;
                        grpSum[s]  = 0;
                        grpCnt[s]  = 0;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    // Offer a constant sample until n handshakes land, within a cycle budget.
    task automatic applyStimulus(input int s, input logic [15:0] value, input int n);
        int got;
        int budget;
        got    = 0;
        budget = n * 4 + 40;
        inValid[s] = 1'b1;
        inData[s]  = value;
        while (got < n && budget > 0) begin
            stepCycle();
            if (hs[s]) got++;
            budget--;
        end
        inValid[s] = 1'b0;
        checkOutput($sformatf("handshakes%0d", s), 32'(got), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN     = 1'b0;
        inValid  = '0;
        clear    = '0;
        outReady = 2'b11;
        inData   = '0;
        for (int s = 0; s < 2; s++) begin
            delivered[s]    = 16'hDEAD;
            deliveredSat[s] = 1'bx;
            expData[s]      = '0;
            expSat[s]       = 1'b0;
        end
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checkOutput($sformatf("rstInReady%0d", s), 32'(inReady[s]), 32'(1));
            checkOutput($sformatf("rstOutValid%0d", s), 32'(outValid[s]), 32'(0));
            checkOutput($sformatf("rstOutData%0d", s), 32'(outData[s]), 32'(0));
            checkOutput($sformatf("rstOutSat%0d", s), 32'(outSat[s]), 32'(0));
        end
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] group of 0x0010");
        delivered[0] = 16'hDEAD;
        applyStimulus(0, 16'h0010, 16);
        repeat (3) stepCycle();
        checkOutput("sum16Data", 32'(delivered[0]), 32'h0010);
        checkOutput("sum16Sat", 32'(deliveredSat[0]), 32'(0));

        $display("[TB] group of -1");
        delivered[0] = 16'hDEAD;
        applyStimulus(0, 16'hFFFF, 16);
        repeat (3) stepCycle();
        checkOutput("minusOneData", 32'(delivered[0]), 32'hFFFF);
        checkOutput("minusOneSat", 32'(deliveredSat[0]), 32'(0));

        $display("[TB] saturation with SHIFT=0");
        delivered[1] = 16'hDEAD;
        applyStimulus(1, 16'h4000, 16);
        repeat (3) stepCycle();
        checkOutput("satHiData", 32'(delivered[1]), 32'h7FFF);
        checkOutput("satHiSat", 32'(deliveredSat[1]), 32'(1));
        delivered[1] = 16'hDEAD;
        applyStimulus(1, 16'h8000, 16);
        repeat (3) stepCycle();
        checkOutput("satLoData", 32'(delivered[1]), 32'h8000);
        checkOutput("satLoSat", 32'(deliveredSat[1]), 32'(1));

        $display("[TB] backpressure");
        delivered[0] = 16'hDEAD;
        outReady[0]  = 1'b0;
        applyStimulus(0, 16'h0001, 16);
        inValid[0] = 1'b1;
        inData[0]  = 16'h0001;
        repeat (5) stepCycle();
        outReady[0] = 1'b1;
        stepCycle();
        checkOutput("stallData", 32'(delivered[0]), 32'h0001);
        delivered[0] = 16'hDEAD;
        applyStimulus(0, 16'h0020, 16);
        repeat (3) stepCycle();
        checkOutput("afterStallData", 32'(delivered[0]), 32'h0020);

        $display("[TB] async reset mid-group");
        applyStimulus(0, 16'h0100, 7);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("midRstInReady", 32'(inReady[0]), 32'(1));
        checkOutput("midRstOutValid", 32'(outValid[0]), 32'(0));
        checkOutput("midRstOutData", 32'(outData[0]), 32'(0));
        modelReset();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        delivered[0] = 16'hDEAD;
        applyStimulus(0, 16'h0001, 16);
        repeat (3) stepCycle();
        checkOutput("postRstData", 32'(delivered[0]), 32'h0001);

        $display("[TB] clear");
        applyStimulus(0, 16'h0100, 5);
        clear[0]   = 1'b1;
        inValid[0] = 1'b1;
        inData[0]  = 16'h0100;
        stepCycle();
        checkOutput("clearConsumes", 32'(hs[0]), 32'(1));
        clear[0]   = 1'b0;
        inValid[0] = 1'b0;
        delivered[0] = 16'hDEAD;
        applyStimulus(0, 16'h0003, 16);
        repeat (3) stepCycle();
        checkOutput("postClearData", 32'(delivered[0]), 32'h0003);

        delivered[0] = 16'hDEAD;
        outReady[0]  = 1'b0;
        applyStimulus(0, 16'h0005, 16);
        clear[0] = 1'b1;
        repeat (2) stepCycle();
        outReady[0] = 1'b1;
        stepCycle();
        clear[0] = 1'b0;
        checkOutput("clearInDrainData", 32'(delivered[0]), 32'h0005);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            for (int s = 0; s < 2; s++) begin
                inValid[s]  = ($urandom_range(0, 3) != 0);
                inData[s]   = 16'($urandom);
                clear[s]    = ($urandom_range(0, 31) == 0);
                outReady[s] = ($urandom_range(0, 2) != 0);
            end
            stepCycle();
        end
        inValid  = '0;
        clear    = '0;
        outReady = 2'b11;
        repeat (3) stepCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
